// File: rtl/mmio_bus_arbiter.sv
// Two-master round-robin arbiter for the FPro MMIO bus. Each transaction is one strobe cycle followed by one ack cycle.
// Define MMIO_ARB_FIXED_PRIO_EN to make m0 always win contention instead of round-robin.
module mmio_bus_arbiter #(
  parameter int AW = 21,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wr_data,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wr_data,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rd_data,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rd_data,
  output logic          mmio_cs,
  output logic          mmio_wr,
  output logic          mmio_rd,
  output logic [AW-1:0] mmio_addr,
  output logic [DW-1:0] mmio_wr_data,
  input  logic [DW-1:0] mmio_rd_data,
  output logic [1:0]    gnt,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t          state;
  logic            pick_m1;
  logic            sel_wr;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wr_data;
`ifndef MMIO_ARB_FIXED_PRIO_EN
  logic            last;
`endif

  // Under contention the master that was not served last time wins.
  always_comb begin
    pick_m1 = m1_req;
    if (m0_req && m1_req) begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
      pick_m1 = 1'b0;
`else
      pick_m1 = ~last;
`endif
    end
    sel_wr      = pick_m1 ? m1_wr      : m0_wr;
    sel_addr    = pick_m1 ? m1_addr    : m0_addr;
    sel_wr_data = pick_m1 ? m1_wr_data : m0_wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      gnt          <= 2'b00;
      busy         <= 1'b0;
      mmio_cs      <= 1'b0;
      mmio_wr      <= 1'b0;
      mmio_rd      <= 1'b0;
      mmio_addr    <= '0;
      mmio_wr_data <= '0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rd_data   <= '0;
      m1_rd_data   <= '0;
`ifndef MMIO_ARB_FIXED_PRIO_EN
      last         <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            state        <= BUS;
            gnt          <= pick_m1 ? 2'b10 : 2'b01;
            busy         <= 1'b1;
            mmio_cs      <= 1'b1;
            mmio_wr      <= sel_wr;
            mmio_rd      <= ~sel_wr;
            mmio_addr    <= sel_addr;
            mmio_wr_data <= sel_wr_data;
          end
        end
        BUS: begin
          // Read data is only valid during the strobe, so capture it here.
          if (mmio_rd) begin
            if (gnt[1]) m1_rd_data <= mmio_rd_data;
            else        m0_rd_data <= mmio_rd_data;
          end
          mmio_cs <= 1'b0;
          mmio_wr <= 1'b0;
          mmio_rd <= 1'b0;
          m0_ack  <= gnt[0];
          m1_ack  <= gnt[1];
          state   <= DONE;
        end
        DONE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          gnt    <= 2'b00;
          busy   <= 1'b0;
`ifndef MMIO_ARB_FIXED_PRIO_EN
          last   <= gnt[1];
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Self-checking bench for mmio_bus_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model. Honours MMIO_ARB_FIXED_PRIO_EN.
module tb_mmio_bus_arbiter;
  localparam int AW = 21;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          req   [2];
  logic          wrv   [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          ackv  [2];
  logic [DW-1:0] rdata [2];
  logic          mmio_cs, mmio_wr, mmio_rd, busy;
  logic [AW-1:0] mmio_addr;
  logic [DW-1:0] mmio_wr_data, mmio_rd_data;
  logic [1:0]    gnt;

  int checks = 0;
  int errors = 0;

  mmio_bus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_wr(wrv[0]), .m0_addr(addr[0]), .m0_wr_data(wdata[0]),
    .m1_req(req[1]), .m1_wr(wrv[1]), .m1_addr(addr[1]), .m1_wr_data(wdata[1]),
    .m0_ack(ackv[0]), .m0_rd_data(rdata[0]),
    .m1_ack(ackv[1]), .m1_rd_data(rdata[1]),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
    .gnt(gnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model: cycles since acceptance (0 = idle, 1 = strobe cycle, 2 = ack cycle).
  int            mPhase;
  int            mOwner;
  int            mLast;
  logic          mWr;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWd;
  logic [DW-1:0] mRd [2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mPhase = 0; mOwner = 0; mLast = 1; mWr = 1'b0;
      mAddr = '0; mWd = '0; mRd[0] = '0; mRd[1] = '0;
    end else begin
      if (mPhase == 0) begin
        if (req[0] || req[1]) begin
          if (req[0] && req[1]) begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
            mOwner = 0;
`else
            mOwner = 1 - mLast;
`endif
          end else begin
            mOwner = req[1] ? 1 : 0;
          end
          mWr = wrv[mOwner]; mAddr = addr[mOwner]; mWd = wdata[mOwner];
          mPhase = 1;
        end
      end else if (mPhase == 1) begin
        if (!mWr) mRd[mOwner] = mmio_rd_data;
        mPhase = 2;
      end else begin
        mLast = mOwner;
        mPhase = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, compare all outputs against the model.
  always @(negedge clk) begin
    checkOutput("cs",      32'(mmio_cs), 32'(mPhase == 1));
    checkOutput("wr",      32'(mmio_wr), 32'(mPhase == 1 && mWr));
    checkOutput("rd",      32'(mmio_rd), 32'(mPhase == 1 && !mWr));
    checkOutput("addr",    32'(mmio_addr), 32'(mAddr));
    checkOutput("wr_data", mmio_wr_data, mWd);
    checkOutput("gnt",     32'(gnt), (mPhase != 0) ? ((mOwner == 1) ? 32'd2 : 32'd1) : 32'd0);
    checkOutput("busy",    32'(busy), 32'(mPhase != 0));
    checkOutput("m0_ack",  32'(ackv[0]), 32'(mPhase == 2 && mOwner == 0));
    checkOutput("m1_ack",  32'(ackv[1]), 32'(mPhase == 2 && mOwner == 1));
    checkOutput("m0_rd",   rdata[0], mRd[0]);
    checkOutput("m1_rd",   rdata[1], mRd[1]);
  end

  task automatic waitCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int m, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[m] = 1'b1; wrv[m] = w; addr[m] = a; wdata[m] = d;
  endtask

  logic [1:0] grants[$];
  logic [1:0] expGrant;
  int         ackCount;
  int         budget;

  initial begin
    reset = 1'b0;
    mmio_rd_data = 32'hDEADBEEF;
    for (int m = 0; m < 2; m++) begin
      req[m] = 1'b0; wrv[m] = 1'b0; addr[m] = '0; wdata[m] = '0;
    end
    repeat (3) waitCycle();
    checkOutput("reset_gnt", 32'(gnt), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    waitCycle();

    // Single read by m0
    applyStimulus(0, 1'b0, 21'h000C0, 32'h0);
    waitCycle();
    checkOutput("rd_strobe_cs", 32'(mmio_cs), 32'd1);
    checkOutput("rd_strobe_rd", 32'(mmio_rd), 32'd1);
    checkOutput("rd_strobe_addr", 32'(mmio_addr), 32'h000C0);
    checkOutput("rd_gnt", 32'(gnt), 32'd1);
    waitCycle();
    checkOutput("rd_ack", 32'(ackv[0]), 32'd1);
    checkOutput("rd_data", rdata[0], 32'hDEADBEEF);
    req[0] = 1'b0;
    waitCycle();
    checkOutput("rd_ack_end", 32'(ackv[0]), 32'd0);
    checkOutput("rd_idle_gnt", 32'(gnt), 32'd0);

    // Single write by m1
    applyStimulus(1, 1'b1, 21'h00180, 32'h00000155);
    waitCycle();
    checkOutput("wr_strobe_wr", 32'(mmio_wr), 32'd1);
    checkOutput("wr_strobe_rd", 32'(mmio_rd), 32'd0);
    checkOutput("wr_strobe_addr", 32'(mmio_addr), 32'h00180);
    checkOutput("wr_strobe_data", mmio_wr_data, 32'h00000155);
    waitCycle();
    checkOutput("wr_ack", 32'(ackv[1]), 32'd1);
    checkOutput("wr_rd_unchanged", rdata[1], 32'd0);
    req[1] = 1'b0;
    waitCycle();

    // Continuous contention for six transactions
    applyStimulus(0, 1'b0, 21'h00010, 32'h0);
    applyStimulus(1, 1'b1, 21'h00020, 32'h77);
    ackCount = 0;
    budget = 0;
    while (ackCount < 6 && budget < 60) begin
      waitCycle();
      budget++;
      if (mmio_cs) grants.push_back(gnt);
      if (ackv[0] || ackv[1]) ackCount++;
    end
    req[0] = 1'b0; req[1] = 1'b0;
    checkOutput("contention_acks", 32'(ackCount), 32'd6);
    checkOutput("contention_grants", 32'(grants.size()), 32'd6);
    for (int i = 0; i < grants.size() && i < 6; i++) begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
      expGrant = 2'b01;
`else
      expGrant = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      checkOutput($sformatf("contention_grant%0d", i), 32'(grants[i]), 32'(expGrant));
    end
    repeat (2) waitCycle();

    // m1 raises req while m0 is in its strobe cycle
    applyStimulus(0, 1'b0, 21'h00030, 32'h0);
    waitCycle();
    checkOutput("late_m0_gnt", 32'(gnt), 32'd1);
    applyStimulus(1, 1'b0, 21'h00044, 32'h0);
    waitCycle();
    checkOutput("late_m0_ack", 32'(ackv[0]), 32'd1);
    checkOutput("late_no_overlap", 32'(mmio_cs), 32'd0);
    req[0] = 1'b0;
    waitCycle();
    checkOutput("late_idle_cs", 32'(mmio_cs), 32'd0);
    waitCycle();
    checkOutput("late_m1_cs", 32'(mmio_cs), 32'd1);
    checkOutput("late_m1_gnt", 32'(gnt), 32'd2);
    checkOutput("late_m1_addr", 32'(mmio_addr), 32'h00044);
    waitCycle();
    checkOutput("late_m1_ack", 32'(ackv[1]), 32'd1);
    req[1] = 1'b0;
    waitCycle();

    // Reset during the strobe cycle
    applyStimulus(0, 1'b0, 21'h00050, 32'h0);
    waitCycle();
    checkOutput("rst_pre_cs", 32'(mmio_cs), 32'd1);
    reset = 1'b0;
    req[0] = 1'b0;
    #1;
    checkOutput("rst_cs", 32'(mmio_cs), 32'd0);
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_addr", 32'(mmio_addr), 32'd0);
    checkOutput("rst_m0_rd", rdata[0], 32'd0);
    waitCycle();
    checkOutput("rst_no_ack", 32'(ackv[0]), 32'd0);
    reset = 1'b1;
    waitCycle();
    mmio_rd_data = 32'h12345678;
    applyStimulus(1, 1'b0, 21'h00060, 32'h0);
    waitCycle();
    checkOutput("post_rst_gnt", 32'(gnt), 32'd2);
    waitCycle();
    checkOutput("post_rst_ack", 32'(ackv[1]), 32'd1);
    checkOutput("post_rst_data", rdata[1], 32'h12345678);
    req[1] = 1'b0;
    waitCycle();

    // Random traffic checked by the per-cycle compare against the model
    for (int c = 0; c < 3000; c++) begin
      waitCycle();
      mmio_rd_data = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        req[0] = 1'b0; req[1] = 1'b0;
        waitCycle();
        reset = 1'b1;
        continue;
      end
      for (int m = 0; m < 2; m++) begin
        if (req[m]) begin
          if (ackv[m]) begin
            if ($urandom_range(0, 1) == 0) req[m] = 1'b0;
            else applyStimulus(m, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
          end else if ($urandom_range(0, 49) == 0) begin
            req[m] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          applyStimulus(m, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        end
      end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (4) waitCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
